// File: rtl/xbar_tile_ctrl_if.sv
// -----------------------------------------------------------------------------
// xbar_tile_ctrl_if
// Bundles the job, PE-handshake, crossbar and output-buffer signals of the
// partial-sum crossbar sequencer.
//   master : environment side (job issuer, PE array, crossbar, buffer writer)
//   slave  : the xbar_tile_ctrl sequencer
// Signals
//   start/pix_num/base_addr   job request, sampled on an accepted start
//   busy/done/err             job status, sticky protocol error
//   pe_valid/pe_ready         PE result-set handshake
//   xbar_valid_i/xbar_valid_o crossbar input strobe / output strobe
//   wr_en/wr_addr             output-buffer write
//   credit_ret                downstream returned one buffer slot
// -----------------------------------------------------------------------------
interface xbar_tile_ctrl_if #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 16
);
  logic              start;
  logic [CNT_W-1:0]  pix_num;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic              pe_valid;
  logic              pe_ready;
  logic              xbar_valid_i;
  logic              xbar_valid_o;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              credit_ret;
  logic              err;

  modport master (
    output start, pix_num, base_addr, pe_valid, xbar_valid_o, credit_ret,
    input  busy, done, pe_ready, xbar_valid_i, wr_en, wr_addr, err
  );

  modport slave (
    input  start, pix_num, base_addr, pe_valid, xbar_valid_o, credit_ret,
    output busy, done, pe_ready, xbar_valid_i, wr_en, wr_addr, err
  );
endinterface

// File: rtl/xbar_tile_ctrl.sv
// -----------------------------------------------------------------------------
// xbar_tile_ctrl
// Sequencer for the 4-to-1 partial-sum crossbar. Accepts a tile job, admits
// PE result sets only while an output-buffer credit is held, drives the
// crossbar valid_i and turns the crossbar valid_o into addressed writes.
// Ports
//   clk, rst : clock, asynchronous active-high reset
//   bus      : xbar_tile_ctrl_if.slave (job, PE, crossbar, buffer signals)
//   perf_stall_cnt (only with XBAR_TILE_PERF_EN defined): cycles in RUN
//              where a PE result was offered but no credit was available.
// Optional feature macro: XBAR_TILE_PERF_EN
// -----------------------------------------------------------------------------
module xbar_tile_ctrl #(
  parameter int CNT_W    = 16,
  parameter int ADDR_W   = 16,
  parameter int CREDITS  = 4,
  parameter int XBAR_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  xbar_tile_ctrl_if.slave     bus
`ifdef XBAR_TILE_PERF_EN
  ,
  output logic [CNT_W-1:0]    perf_stall_cnt
`endif
);

  localparam int CR_W = 4;
  localparam logic [CR_W-1:0] CREDITS_FULL = CR_W'(CREDITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  pix_q;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  completed_q, completed_d;
  logic [CNT_W-1:0]  in_flight_q, in_flight_d;
  logic [ADDR_W-1:0] base_q;
  logic [CR_W-1:0]   credits_q, credits_d;
  logic              err_q, err_d;
  logic              busy_q, done_q;
  logic              lat_q [XBAR_LAT];

  logic active, start_acc, launch, wr_fire, credit_ovf, lat_miss, err_set;

  assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign start_acc = bus.start && (state_q == S_IDLE);

  assign bus.pe_ready     = (state_q == S_RUN) && (issued_q < pix_q) && (credits_q != '0);
  assign launch           = bus.pe_valid && bus.pe_ready;
  assign bus.xbar_valid_i = launch;
  assign wr_fire          = bus.xbar_valid_o && active;
  assign bus.wr_en        = wr_fire;
  assign bus.wr_addr      = base_q + ADDR_W'(completed_q);
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;

  assign issued_d    = issued_q + CNT_W'(launch);
  assign completed_d = completed_q + CNT_W'(wr_fire);
  assign in_flight_d = in_flight_q + CNT_W'(launch) - CNT_W'(wr_fire);

  // A launch and a return in the same cycle cancel; a return on a full pool
  // is a downstream protocol violation and leaves the count saturated.
  assign credit_ovf = bus.credit_ret && !launch && (credits_q == CREDITS_FULL);

  always_comb begin
    credits_d = credits_q;
    if (launch && !bus.credit_ret)
      credits_d = credits_q - 1'b1;
    else if (bus.credit_ret && !launch && !credit_ovf)
      credits_d = credits_q + 1'b1;
  end

  // The oldest stage of the launch shift register says a crossbar result is
  // due this very cycle; the crossbar cannot stall, so absence is an error.
  assign lat_miss = lat_q[XBAR_LAT-1] && !bus.xbar_valid_o;

  assign err_set = (bus.xbar_valid_o && (in_flight_q == '0))
                 || (bus.xbar_valid_o && !active)
                 || lat_miss
                 || credit_ovf;

  // An accepted start clears the sticky flag, but a violation in that same
  // cycle is still recorded.
  assign err_d = (start_acc ? 1'b0 : err_q) || err_set;

  genvar gi;
  generate
    for (gi = 0; gi < XBAR_LAT; gi++) begin : g_lat
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) lat_q[0] <= 1'b0;
          else     lat_q[0] <= launch;
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) lat_q[gi] <= 1'b0;
          else     lat_q[gi] <= lat_q[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pix_q       <= '0;
      base_q      <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      in_flight_q <= '0;
      credits_q   <= CREDITS_FULL;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      issued_q    <= issued_d;
      completed_q <= completed_d;
      in_flight_q <= in_flight_d;
      credits_q   <= credits_d;
      err_q       <= err_d;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            pix_q       <= bus.pix_num;
            base_q      <= bus.base_addr;
            issued_q    <= '0;
            completed_q <= '0;
            busy_q      <= 1'b1;
            if (bus.pix_num != '0) begin
              state_q <= S_RUN;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issued_q == pix_q) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // Look at the post-write count so the last write retires the job
          // in the same cycle it lands.
          if (completed_d == pix_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef XBAR_TILE_PERF_EN
  logic [CNT_W-1:0] perf_q;
  logic             stall;

  assign stall = (state_q == S_RUN) && bus.pe_valid && (issued_q < pix_q)
              && (credits_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_q <= '0;
    else if (start_acc)
      perf_q <= '0;
    else if (stall && (perf_q != '1))
      perf_q <= perf_q + 1'b1;
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: doc/xbar_tile_ctrl.md
Name: xbar_tile_ctrl

Overview:
- Sequencer for the 4-to-1 partial-sum crossbar. The crossbar adds four PE-group results per lane, quantizes to 8 bit, has a fixed 2-cycle latency and cannot stall.
- This block accepts a tile job (pixel count, base address) and admits PE results only when downstream buffer space is guaranteed.
- It drives the crossbar valid_i and turns crossbar valid_o into addressed output-buffer writes.
- It sits between the PE array, the crossbar and the output-buffer writer.

Parameters:
- CNT_W, 16, width of the pixel count and of all internal counters.
- ADDR_W, 16, width of the output-buffer address.
- CREDITS, 4, output-buffer slots available downstream (1..15).
- XBAR_LAT, 2, crossbar latency in cycles. Used only for the latency check.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  job start pulse. Honoured only in IDLE.
- pix_num  in  CNT_W  pixels in the job. Sampled on an accepted start.
- base_addr  in  ADDR_W  first write address. Sampled on an accepted start.
- busy  out  1  high in RUN, DRAIN and DONE.
- done  out  1  one-cycle pulse at job end.
- pe_valid  in  1  PE array has a result set ready.
- pe_ready  out  1  controller accepts the PE result set.
- xbar_valid_i  out  1  drives crossbar valid_i.
- xbar_valid_o  in  1  crossbar valid_o.
- wr_en  out  1  output-buffer write strobe.
- wr_addr  out  ADDR_W  output-buffer write address.
- credit_ret  in  1  downstream freed one slot.
- err  out  1  sticky protocol error. Cleared by rst or an accepted start.

Behaviour:
- Reset (asynchronous): state=IDLE; issued, completed, in_flight=0; credits=CREDITS; err=0. All outputs 0.
- Reset mid-job abandons the job immediately. No done pulse is generated.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start with pix_num!=0. Latch pix_num and base_addr, clear issued/completed/err.
  - IDLE -> DONE on start with pix_num==0.
  - RUN -> DRAIN in the cycle after issued reaches pix_num.
  - DRAIN -> DONE when completed==pix_num.
  - DONE -> IDLE unconditionally after 1 cycle. done=1 only in DONE.
- pe_ready = (state==RUN) & (issued<pix_num) & (credits!=0). Combinational; must not depend on pe_valid.
- launch = pe_valid & pe_ready.
  - xbar_valid_i = launch, combinational, same cycle.
  - On launch: issued+1, in_flight+1.
- Credits:
  - Launch reserves one credit; credit_ret returns one.
  - Simultaneous launch and credit_ret leaves the count unchanged.
  - credit_ret with credits==CREDITS: count saturates and err is set.
- Completion:
  - wr_en = xbar_valid_o & (state==RUN or DRAIN), combinational, aligned with the crossbar data_o.
  - wr_addr = base_addr + completed (mod 2^ADDR_W wrap).
  - On each write: completed+1, in_flight-1.
- Error conditions (each sets err):
  - xbar_valid_o while in_flight==0.
  - xbar_valid_o in IDLE or DONE. No write is produced.
  - A launch not matched by xbar_valid_o exactly XBAR_LAT cycles later (tracked with an XBAR_LAT-deep valid shift register).
- start while busy: ignored, no error.
- Throughput: 1 pixel/cycle when credits never run out. Job time = pix_num + XBAR_LAT + 1 cycles from start to done.

Optional Feature:
- Macro: XBAR_TILE_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt [CNT_W-1:0].
  - Counts cycles in RUN with pe_valid=1, issued<pix_num and credits==0.
  - Cleared on an accepted start and on rst; saturates at all-ones; holds its value after done.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Basic job: rst, start with pix_num=8, base_addr=0x0100, pe_valid=1, credit_ret=1 every cycle.
  - Expect xbar_valid_i high 8 consecutive cycles.
  - Expect wr_en high 8 cycles starting 2 cycles later, wr_addr 0x0100..0x0107.
  - Expect done exactly 11 cycles after start.
- Backpressure: CREDITS=4, pix_num=10, no credit_ret until cycle 20.
  - Expect exactly 4 launches, then pe_ready=0.
  - After 3 credit_ret pulses, expect 3 more launches. Expect err=0.
  - With XBAR_TILE_PERF_EN defined, perf_stall_cnt equals the stall cycles counted.
- Zero and ignored start: start with pix_num=0 -> done 1 cycle later, no xbar_valid_i.
  - A second start during a running 6-pixel job is ignored; exactly 6 writes occur.
- Protocol errors:
  - Inject xbar_valid_o in IDLE -> err=1, wr_en=0.
  - Drop one crossbar valid_o -> err=1, 2 cycles after the unmatched launch.
  - An extra credit_ret at full credits -> err=1.
- Address wrap: base_addr=0xFFFE, pix_num=4 -> wr_addr 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-job: rst asserted after 3 of 8 launches -> all outputs 0 immediately, no done.
  - A following start with pix_num=2 completes normally with err=0.
